bcd_counter_mdigit: RTL
=======================

# bcd_counter_mdigit

Parametrised multi-digit BCD up/down counter, the generalised successor of the single-digit 0–9 counter in the counter/segment-display path. It counts in packed BCD across DIGITS cascaded decades, with direction control, synchronous clear and load, and a registered wrap pulse for chaining. An optional built-in prescaler slows the count rate. Its output feeds the seven-segment display multiplexer directly.

## Interface
- DIGITS, 4: number of BCD decades; legal range 1..8.
- PRESCALE, 4: clock cycles per count step when the prescaler is compiled in; legal range 1..65535.
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- en  in  1  count enable; when low, the count and prescaler state hold.
- up  in  1  direction: 1 counts up, 0 counts down.
- clr  in  1  synchronous clear.
- load  in  1  synchronous load of load_val.
- load_val  in  4*DIGITS  packed BCD load value; digit 0 is in bits [3:0].
- cnt  out  4*DIGITS  packed BCD count, registered.
- wrap  out  1  registered one-cycle pulse on a full-range wrap.

## Operation
- Priority per edge: rst > clr > load > count step > hold.
- rst (asynchronous): cnt=0, wrap=0, prescaler=0.
- clr: cnt=0, wrap=0, prescaler=0.
- load: cnt=load_val. Any nibble >9 is loaded as 0; legal nibbles load unchanged. wrap=0, prescaler=0.
- Count step occurs when en=1 and step_tick=1.
- Up step:
  - Digit 0 increments.
  - A digit at 9 becomes 0 and carries into the next digit.
  - All digits at 9 → all 0, with wrap=1.
- Down step:
  - Digit 0 decrements.
  - A digit at 0 becomes 9 and borrows from the next digit.
  - All digits at 0 → all 9, with wrap=1.
- wrap is 0 in every cycle without a full-range wrap step.
- Direction may change on any cycle. The step uses the value of up sampled on that edge.
- cnt never holds a nibble >9, whatever the stimulus.

## Timing
- cnt and wrap are registered. They update on the same edge that samples en, up, clr and load; there is no extra latency.
- wrap is high for exactly one cycle, the same cycle in which cnt shows the wrapped value.
- Prescaler behaviour when compiled in:
  - step_tick=1 on the edge where the prescaler equals PRESCALE-1; the prescaler returns to 0 on that edge.
  - The prescaler advances only while en=1.
  - With PRESCALE=1, step_tick is constantly 1.
- First step after reset, clr or load comes PRESCALE enabled cycles later.
- rst asserted mid-operation forces all outputs to 0 immediately, without waiting for a clock edge.
- Counting resumes on the first rising edge after rst deasserts.

## Configuration
- BCD_CNT_PRESCALE_EN defined:
  - The internal prescaler is built.
  - A count step occurs once per PRESCALE enabled cycles.
- BCD_CNT_PRESCALE_EN undefined:
  - There is no prescaler logic; step_tick=1.
  - A count step occurs on every edge with en=1.
  - The PRESCALE parameter is ignored.

## Test plan
- Reset and up-count (DIGITS=2, no prescaler):
  - rst pulse → cnt=8'h00, wrap=0.
  - en=1, up=1 for 100 cycles → cnt steps 00,01..99, then 00.
  - wrap=1 only in the cycle where cnt returns to 00.
- Down-count (DIGITS=2): load 8'h01, then en=1, up=0.
  - cnt steps 00, then 99 with wrap=1, then 98.
- Load sanitising and priority:
  - load_val=8'hA7 → cnt=8'h07.
  - clr=1 with load=1, load_val=8'h55 → cnt=8'h00.
  - en=0 for 10 cycles → cnt holds.
- Prescaler (BCD_CNT_PRESCALE_EN, PRESCALE=4, DIGITS=2):
  - en=1 → cnt increments on every 4th edge.
  - en low for 3 cycles mid-interval stretches that interval by 3 cycles.
- Asynchronous reset mid-count:
  - At cnt=8'h47, assert rst between clock edges → cnt=0 and wrap=0 before the next edge.
  - Deassert rst → counting resumes from 00.
- Direction flip at boundary (DIGITS=4):
  - load 16'h9999, up=1 → 0000 with wrap=1.
  - Next cycle up=0 → 9999 with wrap=1.

Source files
------------

// File: rtl/bcd_counter_mdigit.sv
// Multi-digit packed-BCD up/down counter with synchronous clear/load and a registered wrap pulse.
// Define BCD_CNT_PRESCALE_EN to build the internal prescaler (one count step per PRESCALE enabled cycles).
module bcd_counter_mdigit #(
    parameter int unsigned DIGITS   = 4,
    parameter int unsigned PRESCALE = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  up,
    input  logic                  clr,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    output logic [4*DIGITS-1:0]   cnt,
    output logic                  wrap
);

    if (DIGITS == 0 || DIGITS > 8) begin : g_bad_digits
        $error("bcd_counter_mdigit: DIGITS must be 1..8");
    end
    if (PRESCALE == 0 || PRESCALE > 65535) begin : g_bad_prescale
        $error("bcd_counter_mdigit: PRESCALE must be 1..65535");
    end

    logic                step_tick;
    logic [4*DIGITS-1:0] cnt_nxt;
    logic [4*DIGITS-1:0] load_san;
    logic                full_wrap;
    logic                carry;
    logic [3:0]          dig;
    logic [3:0]          dig_nxt;

`ifdef BCD_CNT_PRESCALE_EN
    localparam logic [15:0] PS_LAST = 16'(PRESCALE - 1);
    logic [15:0] pre;

    assign step_tick = (pre == PS_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre <= '0;
        end else if (clr || load) begin
            pre <= '0;
        end else if (en) begin
            pre <= step_tick ? '0 : pre + 16'd1;
        end
    end
`else
    assign step_tick = 1'b1;
`endif

    // Ripple carry/borrow through the decades; a carry out of the top digit is a full-range wrap.
    always_comb begin
        cnt_nxt = cnt;
        carry   = 1'b1;
        dig     = '0;
        dig_nxt = '0;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            dig     = cnt[4*i +: 4];
            dig_nxt = dig;
            if (carry) begin
                if (up) begin
                    if (dig >= 4'd9) begin
                        dig_nxt = 4'd0;
                    end else begin
                        dig_nxt = dig + 4'd1;
                        carry   = 1'b0;
                    end
                end else begin
                    if (dig == 4'd0) begin
                        dig_nxt = 4'd9;
                    end else begin
                        dig_nxt = dig - 4'd1;
                        carry   = 1'b0;
                    end
                end
            end
            cnt_nxt[4*i +: 4] = dig_nxt;
        end
        full_wrap = carry;
    end

    always_comb begin
        load_san = '0;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            load_san[4*i +: 4] = (load_val[4*i +: 4] > 4'd9) ? 4'd0 : load_val[4*i +: 4];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt  <= '0;
            wrap <= 1'b0;
        end else if (clr) begin
            cnt  <= '0;
            wrap <= 1'b0;
        end else if (load) begin
            cnt  <= load_san;
            wrap <= 1'b0;
        end else if (en && step_tick) begin
            cnt  <= cnt_nxt;
            wrap <= full_wrap;
        end else begin
            wrap <= 1'b0;
        end
    end

endmodule
